s3_maxpool_requant: RTL and testbench

- Stage-3 consumer of the stage-2 tensor-processing block's `output_res` array: 4 channels x 6x6 ReLU activations, signed 35-bit, flattened at index `ch*36 + row*6 + col`.
- Performs 2x2/stride-2 max-pooling per channel and requantizes each 35-bit max back to the 17-bit signed data format by arithmetic right-shift plus saturation.
- Produces 4x3x3 = 36 pooled values, held in a result array and also streamed one per cycle.
- Start/busy/done handshake, 2-stage pipeline, one pooled output per clock.

---
 rtl/s3_maxpool_requant_pkg.sv | 26 ++
 rtl/s3_maxpool_requant_max4.sv | 19 +
 rtl/s3_maxpool_requant.sv | 159 +++++++++++++++
 tb/tb_s3_maxpool_requant.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3_maxpool_requant_pkg.sv
// Shared constants, FSM state type and saturation-bound helpers for the
// stage-3 max-pool / requantize block.
package s3_pkg;

   localparam int FM_DIM   = 6;
   localparam int NCH      = 4;
   localparam int POOL_DIM = 3;
   localparam int NPOOL    = 36;
   localparam int FM_SIZE  = 144;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } s3_state_t;

   // Signed rails of a w-bit two's-complement result.
   function automatic longint sat_hi(input int w);
      return (longint'(1) << (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/s3_maxpool_requant_max4.sv
// Combinational signed maximum of four operands as a two-level compare tree.
module max4_signed #(
   parameter int WIDTH = 35
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   input  logic signed [WIDTH-1:0] i_c,
   input  logic signed [WIDTH-1:0] i_d,
   output logic signed [WIDTH-1:0] o_max
);

   logic signed [WIDTH-1:0] w_ab;
   logic signed [WIDTH-1:0] w_cd;

   assign w_ab  = (i_a > i_b) ? i_a : i_b;
   assign w_cd  = (i_c > i_d) ? i_c : i_d;
   assign o_max = (w_ab > w_cd) ? w_ab : w_cd;

endmodule

// File: rtl/s3_maxpool_requant.sv
// 2x2/stride-2 max-pool of a 4x6x6 activation map followed by shift-and-saturate
// requantization; two-stage pipeline, one pooled value per clock.
module s3_maxpool_requant
   import s3_pkg::*;
#(
   parameter int IWIDTH     = 35,
   parameter int OWIDTH     = 17,
   parameter int FRAC_SHIFT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [IWIDTH-1:0] feature_map [FM_SIZE],
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   output logic [5:0]        out_addr,
   output logic [OWIDTH-1:0] out_data,
   output logic [OWIDTH-1:0] pooled [NPOOL]
);

   localparam logic signed [IWIDTH-1:0] W_HI = IWIDTH'(sat_hi(OWIDTH));
   localparam logic signed [IWIDTH-1:0] W_LO = IWIDTH'(sat_lo(OWIDTH));

   s3_state_t                   r_state;
   logic [$clog2(NCH)-1:0]      r_ch;
   logic [1:0]                  r_prow;
   logic [1:0]                  r_pcol;
   logic [5:0]                  r_idx;
   logic                        r_drain;
   logic                        r_busy;
   logic                        r_s1_valid;
   logic [5:0]                  r_s1_addr;
   logic signed [IWIDTH-1:0]    r_s1_max;
   logic                        r_out_valid;
   logic [5:0]                  r_out_addr;
   logic [OWIDTH-1:0]           r_out_data;
   logic                        r_done;
   logic [OWIDTH-1:0]           r_pooled [NPOOL];

   logic [7:0]                  w_base;
   logic signed [IWIDTH-1:0]    w_max;
   logic signed [IWIDTH-1:0]    w_shift;
   logic [OWIDTH-1:0]           w_sat;

   // Top-left element of the current 2x2 window.
   assign w_base = 8'(r_ch) * 8'(FM_DIM * FM_DIM) + 8'(r_prow) * 8'(2 * FM_DIM)
                 + {5'd0, r_pcol, 1'b0};

   max4_signed #(.WIDTH(IWIDTH)) u_max4 (
      .i_a   (feature_map[w_base]),
      .i_b   (feature_map[w_base + 8'd1]),
      .i_c   (feature_map[w_base + 8'(FM_DIM)]),
      .i_d   (feature_map[w_base + 8'(FM_DIM + 1)]),
      .o_max (w_max)
   );

   assign w_shift = r_s1_max >>> FRAC_SHIFT;

   always_comb begin
      w_sat = w_shift[OWIDTH-1:0];
      if (w_shift > W_HI) begin
         w_sat = W_HI[OWIDTH-1:0];
      end else if (w_shift < W_LO) begin
         w_sat = W_LO[OWIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_prow  <= '0;
         r_pcol  <= '0;
         r_idx   <= '0;
         r_drain <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_ch    <= '0;
                  r_prow  <= '0;
                  r_pcol  <= '0;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_idx <= r_idx + 6'd1;
               if (r_pcol == 2'(POOL_DIM - 1)) begin
                  r_pcol <= '0;
                  if (r_prow == 2'(POOL_DIM - 1)) begin
                     r_prow <= '0;
                     r_ch   <= r_ch + 1'b1;
                  end else begin
                     r_prow <= r_prow + 2'd1;
                  end
               end else begin
                  r_pcol <= r_pcol + 2'd1;
               end
               if (r_idx == 6'(NPOOL - 1)) begin
                  r_state <= DRAIN;
                  r_drain <= 1'b0;
               end
            end
            DRAIN: begin
               // Second drain cycle is the done cycle; start stays ignored through it.
               r_drain <= 1'b1;
               if (r_drain) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_addr   <= '0;
         r_s1_max    <= '0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_done      <= 1'b0;
         for (int i = 0; i < NPOOL; i++) begin
            r_pooled[i] <= '0;
         end
      end else begin
         r_s1_valid  <= (r_state == RUN);
         r_s1_addr   <= r_idx;
         r_s1_max    <= w_max;
         r_out_valid <= r_s1_valid;
         r_done      <= r_s1_valid && (r_s1_addr == 6'(NPOOL - 1));
         if (r_s1_valid) begin
            r_out_addr            <= r_s1_addr;
            r_out_data            <= w_sat;
            r_pooled[r_s1_addr]   <= w_sat;
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign out_valid = r_out_valid;
   assign out_addr  = r_out_addr;
   assign out_data  = r_out_data;

   generate
      for (genvar gi = 0; gi < NPOOL; gi++) begin : g_pooled
         assign pooled[gi] = r_pooled[gi];
      end
   endgenerate

endmodule

// File: tb/tb_s3_maxpool_requant.sv
// Scoreboard bench for s3_maxpool_requant: expected beats are queued at start
// and popped by a monitor as out_valid beats appear.
module tb_s3_maxpool_requant;
   import s3_pkg::*;

   localparam int IW = 35;
   localparam int OW = 17;
   localparam int SH = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] fm [FM_SIZE];
   logic          busy, done, out_valid;
   logic [5:0]    out_addr;
   logic [OW-1:0] out_data;
   logic [OW-1:0] pooled [NPOOL];

   int checks = 0;
   int failures = 0;
   int beats = 0;
   int dones = 0;

   typedef struct packed {
      logic [5:0]    addr;
      logic [OW-1:0] data;
   } beat_t;
   beat_t exp_q[$];

   s3_maxpool_requant #(.IWIDTH(IW), .OWIDTH(OW), .FRAC_SHIFT(SH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .feature_map (fm),
      .busy        (busy),
      .done        (done),
      .out_valid   (out_valid),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .pooled      (pooled)
   );

   always #5 clk = ~clk;

   // Reference: 64-bit signed max, arithmetic shift, clamp to 17-bit rails.
   function automatic logic [OW-1:0] model(input int idx);
      int ch, pr, pc, b;
      longint m, v, s;
      int offs [4];
      offs[0] = 0; offs[1] = 1; offs[2] = 6; offs[3] = 7;
      ch = idx / 9;
      pr = (idx % 9) / 3;
      pc = idx % 3;
      b  = ch * 36 + pr * 12 + pc * 2;
      m  = longint'($signed(fm[b]));
      for (int k = 1; k < 4; k++) begin
         v = longint'($signed(fm[b + offs[k]]));
         if (v > m) m = v;
      end
      s = m >>> SH;
      if (s > 65535) s = 65535;
      if (s < -65536) s = -65536;
      return OW'(s);
   endfunction

   always @(negedge clk) begin
      beat_t e;
      if (!reset) begin
         if (done) dones++;
         if (out_valid) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat got addr=%0d data=%0d want no beat",
                        out_addr, $signed(out_data));
            end else begin
               e = exp_q.pop_front();
               if (out_addr !== e.addr || out_data !== e.data) begin
                  failures++;
                  $display("FAIL beat got addr=%0d data=%0d want addr=%0d data=%0d",
                           out_addr, $signed(out_data), e.addr, $signed(e.data));
               end else begin
                  $display("beat addr=%0d data=%0d", out_addr, $signed(out_data));
               end
            end
         end
      end
   end

   task automatic push_expected();
      for (int i = 0; i < NPOOL; i++) exp_q.push_back({6'(i), model(i)});
   endtask

   task automatic fill(input longint val);
      for (int i = 0; i < FM_SIZE; i++) fm[i] = IW'(val);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < FM_SIZE; i++) fm[i] = IW'(longint'(i) << 8);
   endtask

   // Starts a run, optionally re-pulses start after edges E0+pa / E0+pb,
   // returns the edge index of done; ends just after edge E0+done_n+1.
   task automatic run_once(input int pa, input int pb, output int done_n,
                           output logic [5:0] addr_at_done, output logic valid_at_done);
      done_n = -1;
      addr_at_done = '0;
      valid_at_done = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         start = (n == pa) || (n == pb);
         if (n == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_after_start got %0b want 1", busy);
            end
         end
         if (done) begin
            done_n = n;
            addr_at_done = out_addr;
            valid_at_done = out_valid;
            break;
         end
      end
      checks++;
      if (done_n < 0) begin
         failures++;
         $display("FAIL run_timeout got no done want done within 60 cycles");
      end
      @(posedge clk);
      #1 start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_done got busy=%0b done=%0b want 0 0", busy, done);
      end
   endtask

   task automatic test_reset();
      int nz;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nz = 0;
      for (int i = 0; i < NPOOL; i++) if (pooled[i] !== '0) nz++;
      checks++;
      if ({busy, done, out_valid} !== 3'b000 || out_addr !== 6'd0 || out_data !== '0 || nz != 0) begin
         failures++;
         $display("FAIL reset_state got busy=%0b done=%0b valid=%0b addr=%0d data=%0d nz_pooled=%0d want all 0",
                  busy, done, out_valid, out_addr, out_data, nz);
      end
      @(negedge clk) reset = 1'b0;
      beats = 0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (beats != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got beats=%0d busy=%0b want 0 0", beats, busy);
      end
   endtask

   task automatic test_ramp();
      int dn;
      logic [5:0] a;
      logic v;
      fill_ramp();
      push_expected();
      beats = 0; dones = 0;
      run_once(-1, -1, dn, a, v);
      // done follows edge E0+37: 38 cycles counting the start cycle.
      checks++;
      if (dn != 37) begin failures++; $display("FAIL ramp_done_cycle got %0d want 37", dn); end
      checks++;
      if (a !== 6'd35 || v !== 1'b1) begin
         failures++;
         $display("FAIL ramp_done_coincident got addr=%0d valid=%0b want 35 1", a, v);
      end
      checks++;
      if (pooled[0] !== 17'd7 || pooled[1] !== 17'd9 || pooled[8] !== 17'd35 || pooled[35] !== 17'd143) begin
         failures++;
         $display("FAIL ramp_pooled got %0d %0d %0d %0d want 7 9 35 143",
                  pooled[0], pooled[1], pooled[8], pooled[35]);
      end
      checks++;
      if (beats != 36 || dones != 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL ramp_counts got beats=%0d dones=%0d left=%0d want 36 1 0", beats, dones, exp_q.size());
      end
   endtask

   task automatic test_saturation();
      int dn;
      logic [5:0] a;
      logic v;
      fill(longint'(1) << 30);
      push_expected();
      run_once(-1, -1, dn, a, v);
      checks++;
      if (pooled[0] !== 17'h0FFFF || pooled[35] !== 17'h0FFFF) begin
         failures++;
         $display("FAIL sat_pos got %0d %0d want 65535 65535", $signed(pooled[0]), $signed(pooled[35]));
      end
      for (int i = 36; i < 72; i++) fm[i] = IW'(-(longint'(1) << 30));
      push_expected();
      run_once(-1, -1, dn, a, v);
      for (int i = 9; i <= 17; i++) begin
         checks++;
         if (pooled[i] !== 17'h10000) begin
            failures++;
            $display("FAIL sat_neg[%0d] got %0d want -65536", i, $signed(pooled[i]));
         end
      end
      checks++;
      if (pooled[8] !== 17'h0FFFF || pooled[18] !== 17'h0FFFF) begin
         failures++;
         $display("FAIL sat_neighbours got %0d %0d want 65535 65535", $signed(pooled[8]), $signed(pooled[18]));
      end
   endtask

   task automatic test_max_select();
      int dn;
      logic [5:0] a;
      logic v;
      fill(0);
      fm[0] = IW'(5 << 8); fm[1] = IW'(100 << 8); fm[6] = IW'(3 << 8); fm[7] = IW'(99 << 8);
      push_expected();
      run_once(-1, -1, dn, a, v);
      checks++;
      if (pooled[0] !== 17'd100) begin failures++; $display("FAIL max_b1 got %0d want 100", $signed(pooled[0])); end
      fill(0);
      fm[7] = IW'(50 << 8);
      fm[72] = IW'(-(longint'(1000) << 8)); fm[73] = IW'(-(longint'(3) << 8));
      fm[78] = IW'(-(longint'(7) << 8));    fm[79] = IW'(-(longint'(2000) << 8));
      push_expected();
      run_once(-1, -1, dn, a, v);
      checks++;
      if (pooled[0] !== 17'd50) begin failures++; $display("FAIL max_b7 got %0d want 50", $signed(pooled[0])); end
      checks++;
      if (pooled[18] !== 17'h1FFFD) begin failures++; $display("FAIL max_neg got %0d want -3", $signed(pooled[18])); end
   endtask

   task automatic test_start_while_busy();
      int dn;
      logic [5:0] a;
      logic v;
      fill_ramp();
      push_expected();
      beats = 0; dones = 0;
      run_once(5, 37, dn, a, v);
      checks++;
      if (dn != 37 || beats != 36 || dones != 1) begin
         failures++;
         $display("FAIL busy_start_run1 got done_at=%0d beats=%0d dones=%0d want 37 36 1", dn, beats, dones);
      end
      // Launched in the first IDLE cycle after done.
      push_expected();
      beats = 0; dones = 0;
      run_once(-1, -1, dn, a, v);
      checks++;
      if (dn != 37 || beats != 36 || dones != 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL busy_start_run2 got done_at=%0d beats=%0d dones=%0d left=%0d want 37 36 1 0",
                  dn, beats, dones, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      int dn, nz;
      logic [5:0] a;
      logic v;
      fill_ramp();
      push_expected();
      beats = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < 60 && beats < 20; n++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (beats < 20) begin failures++; $display("FAIL midrun_wait got beats=%0d want 20", beats); end
      #2 reset = 1'b1;
      #1;
      nz = 0;
      for (int i = 0; i < NPOOL; i++) if (pooled[i] !== '0) nz++;
      checks++;
      if ({busy, done, out_valid} !== 3'b000 || out_addr !== 6'd0 || out_data !== '0 || nz != 0) begin
         failures++;
         $display("FAIL async_reset got busy=%0b done=%0b valid=%0b addr=%0d data=%0d nz_pooled=%0d want all 0",
                  busy, done, out_valid, out_addr, out_data, nz);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      beats = 0;
      repeat (45) @(posedge clk);
      #1;
      checks++;
      if (beats != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_quiet got beats=%0d busy=%0b want 0 0", beats, busy);
      end
      push_expected();
      beats = 0;
      run_once(-1, -1, dn, a, v);
      checks++;
      if (dn != 37 || beats != 36) begin
         failures++;
         $display("FAIL post_reset_run got done_at=%0d beats=%0d want 37 36", dn, beats);
      end
   endtask

   task automatic test_back_to_back();
      int dn;
      logic [5:0] a;
      logic v;
      fill_ramp();
      push_expected();
      run_once(-1, -1, dn, a, v);
      fill(0);
      push_expected();
      run_once(-1, -1, dn, a, v);
      for (int i = 0; i < NPOOL; i++) begin
         checks++;
         if (pooled[i] !== '0) begin
            failures++;
            $display("FAIL b2b_stale[%0d] got %0d want 0", i, $signed(pooled[i]));
         end
      end
   endtask

   initial begin
      fill(0);
      test_reset();
      test_ramp();
      test_saturation();
      test_max_select();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
